// File: rtl/rng_ctrl_pkg.sv
// Shared definitions for the RNG FIFO controller: register map, STATUS layout, FSM states.
package rng_ctrl_pkg;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_SEED   = 2'd2;
   localparam logic [1:0] REG_CTRL   = 2'd3;

   localparam int ST_EMPTY     = 16;
   localparam int ST_FULL      = 17;
   localparam int ST_UNDERFLOW = 18;
   localparam int ST_BUSY      = 19;
   localparam int ST_HEALTH    = 20;

   localparam logic [31:0] EMPTY_WORD_DEFAULT = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_SEED
   } state_t;

endpackage

// File: rtl/rng_sync_fifo.sv
// Small synchronous FIFO for random words: push/pop/flush with level, empty and full.
module rng_sync_fifo #(
   parameter int DEPTH_LOG2 = 3,
   parameter int WIDTH      = 32
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  push,
   input  logic                  pop,
   input  logic                  flush,
   input  logic [WIDTH-1:0]      data_in,
   output logic [WIDTH-1:0]      data_out,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  empty,
   output logic                  full
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2:0]   LVL_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_reg;
   logic [DEPTH_LOG2-1:0] rd_ptr_reg;
   logic [DEPTH_LOG2:0]   level_reg;
   logic                  push_ok;
   logic                  pop_ok;

   assign empty    = (level_reg == '0);
   assign full     = level_reg[DEPTH_LOG2];
   assign level    = level_reg;
   assign push_ok  = push && !full && !flush;
   assign pop_ok   = pop && !empty && !flush;
   // Head is read straight from the array; the caller registers it on the bus side.
   assign data_out = mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn || flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         end
         unique case ({push_ok, pop_ok})
            2'b10:   level_reg <= level_reg + LVL_ONE;
            2'b01:   level_reg <= level_reg - LVL_ONE;
            default: level_reg <= level_reg;
         endcase
      end
   end

endmodule

// File: rtl/rng_fifo_ctrl.sv
// iomem-to-simplerng sequencer: prefetches random words into a FIFO and serves CPU reads.
// Optional repetition health test enabled by defining RNG_HEALTH_EN.
module rng_fifo_ctrl
   import rng_ctrl_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h0300_1000,
   parameter int          DEPTH_LOG2 = 3,
   parameter logic [31:0] EMPTY_WORD = EMPTY_WORD_DEFAULT
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        iomem_valid,
   output logic        iomem_ready,
   input  logic [3:0]  iomem_wstrb,
   input  logic [31:0] iomem_addr,
   input  logic [31:0] iomem_wdata,
   output logic [31:0] iomem_rdata,
   output logic        rng_enable,
   output logic        rng_dat_we,
   output logic        rng_dat_re,
   output logic [31:0] rng_dat_di,
   input  logic [31:0] rng_dat_do,
   input  logic        rng_dat_wait
);

   state_t              state_reg, state_next;
   logic                ready_reg;
   logic [31:0]         rdata_reg;
   logic                run_reg;
   logic [31:0]         seed_reg;
   logic                seed_pending_reg;
   logic                underflow_reg;
   logic                health_fail_reg;

   logic                sel, is_wr, rd_sel, wr_sel, data_rd;
   logic [1:0]          reg_idx;
   logic [31:0]         status_word;
   logic [31:0]         rd_value;
   logic                capture, health_check, repeat_hit, health_set, health_trip;
   logic                fifo_push, fifo_pop, fifo_flush;
   logic [31:0]         fifo_data;
   logic [DEPTH_LOG2:0] fifo_level;
   logic                fifo_empty, fifo_full;
   logic                addr_unused;

   assign addr_unused = &{1'b0, iomem_addr[1:0]};

   assign sel     = iomem_valid && (iomem_addr[31:4] == BASE_ADDR[31:4]) && !ready_reg;
   assign is_wr   = |iomem_wstrb;
   assign reg_idx = iomem_addr[3:2];
   assign rd_sel  = sel && !is_wr;
   assign wr_sel  = sel && is_wr;
   assign data_rd = rd_sel && (reg_idx == REG_DATA);
   assign fifo_pop = data_rd && !fifo_empty;

   assign capture      = (state_reg == S_WAIT) && !rng_dat_wait;
   // A seed queued while sampling invalidates the word in flight.
   assign health_check = capture && !seed_pending_reg;
   assign health_set   = health_check && repeat_hit;
   assign fifo_push    = health_check && !repeat_hit;

`ifdef RNG_HEALTH_EN
   logic [31:0] prev_word_reg;
   logic        prev_valid_reg;
   logic [1:0]  repeat_cnt_reg;

   assign repeat_hit  = prev_valid_reg && (rng_dat_do == prev_word_reg);
   assign health_trip = health_set && (repeat_cnt_reg == 2'd3);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         prev_word_reg  <= '0;
         prev_valid_reg <= 1'b0;
         repeat_cnt_reg <= '0;
      end else if (health_check) begin
         prev_word_reg  <= rng_dat_do;
         prev_valid_reg <= 1'b1;
         repeat_cnt_reg <= repeat_hit ? repeat_cnt_reg + 2'd1 : 2'd0;
      end
   end
`else
   assign repeat_hit  = 1'b0;
   assign health_trip = 1'b0;
`endif

   rng_sync_fifo #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .WIDTH      (32)
   ) u_fifo (
      .clk      (clk),
      .resetn   (resetn),
      .push     (fifo_push),
      .pop      (fifo_pop),
      .flush    (fifo_flush),
      .data_in  (rng_dat_do),
      .data_out (fifo_data),
      .level    (fifo_level),
      .empty    (fifo_empty),
      .full     (fifo_full)
   );

   always_comb begin
      status_word                 = '0;
      status_word[DEPTH_LOG2:0]   = fifo_level;
      status_word[ST_EMPTY]       = fifo_empty;
      status_word[ST_FULL]        = fifo_full;
      status_word[ST_UNDERFLOW]   = underflow_reg;
      status_word[ST_BUSY]        = (state_reg != S_IDLE);
      status_word[ST_HEALTH]      = health_fail_reg;
   end

   always_comb begin
      rd_value = '0;
      unique case (reg_idx)
         REG_DATA:   rd_value = fifo_empty ? EMPTY_WORD : fifo_data;
         REG_STATUS: rd_value = status_word;
         REG_SEED:   rd_value = '0;
         REG_CTRL:   rd_value = {31'b0, run_reg};
         default:    rd_value = '0;
      endcase
   end

   always_comb begin
      state_next = state_reg;
      rng_dat_re = 1'b0;
      rng_dat_we = 1'b0;
      fifo_flush = 1'b0;
      unique case (state_reg)
         S_IDLE: begin
            if (seed_pending_reg) begin
               state_next = S_SEED;
            end else if (run_reg && !fifo_full) begin
               state_next = S_REQ;
            end
         end
         S_REQ: begin
            rng_dat_re = 1'b1;
            state_next = S_WAIT;
         end
         S_WAIT: begin
            if (!rng_dat_wait) begin
               state_next = S_IDLE;
            end
         end
         S_SEED: begin
            rng_dat_we = 1'b1;
            fifo_flush = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_reg        <= S_IDLE;
         ready_reg        <= 1'b0;
         rdata_reg        <= '0;
         run_reg          <= 1'b1;
         seed_pending_reg <= 1'b0;
         underflow_reg    <= 1'b0;
         health_fail_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         ready_reg <= sel;
         if (sel) begin
            rdata_reg <= is_wr ? 32'h0 : rd_value;
         end
         if (wr_sel && (reg_idx == REG_SEED)) begin
            seed_pending_reg <= 1'b1;
         end else if (state_reg == S_SEED) begin
            seed_pending_reg <= 1'b0;
         end
         if (data_rd && fifo_empty) begin
            underflow_reg <= 1'b1;
         end else if (wr_sel && (reg_idx == REG_STATUS) && iomem_wstrb[0]
                      && iomem_wdata[ST_UNDERFLOW]) begin
            underflow_reg <= 1'b0;
         end
         if (health_set) begin
            health_fail_reg <= 1'b1;
         end else if (wr_sel && (reg_idx == REG_STATUS) && iomem_wstrb[0]
                      && iomem_wdata[ST_HEALTH]) begin
            health_fail_reg <= 1'b0;
         end
         // A tripped health test overrides a simultaneous CTRL write.
         if (health_trip) begin
            run_reg <= 1'b0;
         end else if (wr_sel && (reg_idx == REG_CTRL) && iomem_wstrb[0]) begin
            run_reg <= iomem_wdata[0];
         end
      end
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_seed_lane
         always_ff @(posedge clk) begin
            if (!resetn) begin
               seed_reg[gi*8 +: 8] <= '0;
            end else if (wr_sel && (reg_idx == REG_SEED) && iomem_wstrb[gi]) begin
               seed_reg[gi*8 +: 8] <= iomem_wdata[gi*8 +: 8];
            end
         end
      end
   endgenerate

   assign iomem_ready = ready_reg;
   assign iomem_rdata = rdata_reg;
   assign rng_enable  = run_reg;
   assign rng_dat_di  = seed_reg;

endmodule

// File: tb/tb_rng_fifo_ctrl.sv
// Directed self-checking bench for rng_fifo_ctrl with a 3-wait-cycle RNG model.
module tb_rng_fifo_ctrl;

   localparam logic [31:0] BASE = 32'h0300_1000;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        iomem_valid = 1'b0;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb = 4'h0;
   logic [31:0] iomem_addr = 32'h0;
   logic [31:0] iomem_wdata = 32'h0;
   logic [31:0] iomem_rdata;
   logic        rng_enable;
   logic        rng_dat_we;
   logic        rng_dat_re;
   logic [31:0] rng_dat_di;
   logic [31:0] rng_dat_do = 32'h0;
   logic        rng_dat_wait = 1'b0;

   int          n_checks = 0;
   int          n_fail = 0;
   int          re_count = 0;
   int          we_cycles = 0;
   logic [31:0] seed_seen = 32'h0;
   int          sample_n = 0;
   int          busy_cnt = 0;
   logic        const_mode = 1'b0;
   logic [31:0] q;

   always #5 clk = ~clk;

   rng_fifo_ctrl #(
      .BASE_ADDR  (BASE),
      .DEPTH_LOG2 (3),
      .EMPTY_WORD (32'hFFFF_FFFF)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .iomem_valid  (iomem_valid),
      .iomem_ready  (iomem_ready),
      .iomem_wstrb  (iomem_wstrb),
      .iomem_addr   (iomem_addr),
      .iomem_wdata  (iomem_wdata),
      .iomem_rdata  (iomem_rdata),
      .rng_enable   (rng_enable),
      .rng_dat_we   (rng_dat_we),
      .rng_dat_re   (rng_dat_re),
      .rng_dat_di   (rng_dat_di),
      .rng_dat_do   (rng_dat_do),
      .rng_dat_wait (rng_dat_wait)
   );

   // RNG model: busy for 3 cycles after each request, then presents 0x1000_0000+n.
   always @(posedge clk) begin
      if (!resetn) begin
         busy_cnt     <= 0;
         rng_dat_wait <= 1'b0;
      end else if (rng_dat_re) begin
         busy_cnt     <= 3;
         rng_dat_wait <= 1'b1;
      end else if (busy_cnt > 1) begin
         busy_cnt <= busy_cnt - 1;
      end else if (busy_cnt == 1) begin
         busy_cnt     <= 0;
         rng_dat_wait <= 1'b0;
         rng_dat_do   <= const_mode ? 32'h1234_5678 : 32'h1000_0000 + sample_n;
         sample_n     <= sample_n + 1;
      end
   end

   always @(posedge clk) begin
      if (resetn && rng_dat_re) re_count <= re_count + 1;
      if (resetn && rng_dat_we) begin
         we_cycles <= we_cycles + 1;
         seed_seen <= rng_dat_di;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                      output logic [31:0] r);
      @(negedge clk);
      iomem_valid = 1'b1;
      iomem_addr  = a;
      iomem_wstrb = s;
      iomem_wdata = d;
      @(posedge clk); #1;
      check_eq("ready_pulse", {31'b0, iomem_ready}, 32'd1);
      r = iomem_rdata;
      iomem_valid = 1'b0;
      @(posedge clk); #1;
      check_eq("ready_drop", {31'b0, iomem_ready}, 32'd0);
      $display("bus addr=%h wstrb=%h wdata=%h rdata=%h", a, s, d, r);
   endtask

   task automatic rd(input logic [3:0] off, input logic [31:0] exp, input string tag);
      logic [31:0] r;
      bus(BASE + {28'h0, off}, 4'h0, 32'h0, r);
      check_eq(tag, r, exp);
   endtask

   task automatic wr(input logic [3:0] off, input logic [31:0] d);
      logic [31:0] r;
      bus(BASE + {28'h0, off}, 4'hF, d, r);
   endtask

   task automatic wait_rng(input logic lvl, input string tag);
      for (int i = 0; i < 50 && rng_dat_wait !== lvl; i++) begin
         @(posedge clk); #1;
      end
      check_eq(tag, {31'b0, rng_dat_wait}, {31'b0, lvl});
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_ready", {31'b0, iomem_ready}, 32'd0);
      check_eq("rst_rdata", iomem_rdata, 32'h0);
      check_eq("rst_re", {31'b0, rng_dat_re}, 32'd0);
      check_eq("rst_we", {31'b0, rng_dat_we}, 32'd0);
      check_eq("rst_di", rng_dat_di, 32'h0);
      check_eq("rst_enable", {31'b0, rng_enable}, 32'd1);
      @(negedge clk);
      resetn = 1'b1;

      // Unselected window never acknowledges
      @(negedge clk);
      iomem_valid = 1'b1;
      iomem_addr  = 32'h0300_2000;
      iomem_wstrb = 4'h0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check_eq("unsel_ready", {31'b0, iomem_ready}, 32'd0);
      end
      iomem_valid = 1'b0;

      // Initial fill
      repeat (80) @(posedge clk);
      #1;
      rd(4'h4, 32'h0002_0008, "fill_status");
      check_eq("fill_re_count", re_count, 32'd8);

      rd(4'h0, 32'h1000_0000, "pop0");
      rd(4'h0, 32'h1000_0001, "pop1");
      rd(4'h0, 32'h1000_0002, "pop2");
      repeat (40) @(posedge clk);
      #1;
      rd(4'h4, 32'h0002_0008, "refill_status");
      check_eq("refill_re_count", re_count, 32'd11);

      // Stop, drain, underflow and W1C
      wr(4'hC, 32'h0);
      rd(4'hC, 32'h0, "ctrl_off");
      for (int i = 0; i < 8; i++) begin
         rd(4'h0, 32'h1000_0003 + i, "drain");
      end
      rd(4'h0, 32'hFFFF_FFFF, "empty_word");
      rd(4'h4, 32'h0005_0000, "underflow_status");
      wr(4'h4, 32'h0004_0000);
      rd(4'h4, 32'h0001_0000, "w1c_status");
      rd(4'h8, 32'h0, "seed_read");

      // Seed arrives while a sample is in flight
      wr(4'hC, 32'h1);
      wait_rng(1'b1, "seed_wait_busy");
      wr(4'h8, 32'hDEAD_BEEF);
      for (int i = 0; i < 50 && we_cycles == 0; i++) begin
         @(posedge clk); #1;
      end
      bus(BASE + 32'h4, 4'h0, 32'h0, q);
      check_eq("seed_level", q & 32'h0001_000F, 32'h0001_0000);
      check_eq("seed_value", seed_seen, 32'hDEAD_BEEF);
      repeat (80) @(posedge clk);
      #1;
      check_eq("we_cycles", we_cycles, 32'd1);
      rd(4'h4, 32'h0002_0008, "seed_refill_status");
      check_eq("seed_re_count", re_count, 32'd20);
      rd(4'h0, 32'h1000_000C, "seed_discard");

      // Pop coincident with push at level 5
      wr(4'hC, 32'h0);
      repeat (20) @(posedge clk);
      #1;
      rd(4'h0, 32'h1000_000D, "pre_pop0");
      rd(4'h0, 32'h1000_000E, "pre_pop1");
      rd(4'h0, 32'h1000_000F, "pre_pop2");
      wr(4'hC, 32'h1);
      wr(4'hC, 32'h0);
      wait_rng(1'b1, "cc_busy");
      wait_rng(1'b0, "cc_done");
      rd(4'h0, 32'h1000_0010, "cc_pop");
      rd(4'h4, 32'h0000_0005, "cc_level");
      for (int i = 0; i < 5; i++) begin
         rd(4'h0, 32'h1000_0011 + i, "cc_order");
      end
      rd(4'h0, 32'hFFFF_FFFF, "cc_empty");
      check_eq("final_re_count", re_count, 32'd22);

`ifdef RNG_HEALTH_EN
      const_mode = 1'b1;
      wr(4'hC, 32'h1);
      repeat (60) @(posedge clk);
      #1;
      rd(4'h4, 32'h0014_0001, "health_status");
      rd(4'hC, 32'h0, "health_run");
      check_eq("health_re_count", re_count, 32'd27);
      rd(4'h0, 32'h1234_5678, "health_word");
`else
      bus(BASE + 32'h4, 4'h0, 32'h0, q);
      check_eq("health_bit", q & 32'h0010_0000, 32'h0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rng_fifo_ctrl.md
Name: rng_fifo_ctrl

Overview:
Sequencer and buffer between the PicoSoC iomem bus and the simplerng random-number core. Autonomously issues read requests to the RNG and fills a small FIFO of 32-bit random words. Serves CPU reads from the FIFO with single-cycle ready, and forwards seed writes and a run control to the RNG. Replaces direct iomem-to-RNG wiring in the top level.

Parameters:
BASE_ADDR, 32'h0300_1000, iomem base of the 16-byte register window
DEPTH_LOG2, 3, FIFO depth = 2**DEPTH_LOG2 words (8)
EMPTY_WORD, 32'hFFFF_FFFF, DATA read value when FIFO empty

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
iomem_valid  in  1  bus request valid
iomem_ready  out  1  bus acknowledge, one-cycle pulse
iomem_wstrb  in  4  byte strobes; 0 = read
iomem_addr  in  32  byte address
iomem_wdata  in  32  write data
iomem_rdata  out  32  registered read data
rng_enable  out  1  RNG enable (= CTRL.run)
rng_dat_we  out  1  seed write strobe, one cycle
rng_dat_re  out  1  sample request, one cycle
rng_dat_di  out  32  seed value
rng_dat_do  in  32  RNG output word
rng_dat_wait  in  1  RNG busy

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous and active-low on resetn. Reset: iomem_ready=0, iomem_rdata=0, rng_dat_we=0, rng_dat_re=0, rng_dat_di=0, FIFO empty, sticky flags 0, FSM S_IDLE, run=1 (rng_enable=1 after first reset edge). Reset mid-operation aborts any in-flight sample; no word pushed.
- Select: iomem_valid && addr[31:4]==BASE_ADDR[31:4] && !iomem_ready. Unselected addresses never raise ready.
- Ready: one cycle after select, ready=1 for exactly one cycle with rdata registered; then 0.
- Registers (offset): 0x0 DATA R: pop head; empty -> EMPTY_WORD, set underflow. Writes ignored. 0x4 STATUS R: [DEPTH_LOG2:0] level, [16] empty, [17] full, [18] underflow (sticky), [19] busy (FSM!=S_IDLE), [20] health_fail; W1C on bits 18, 20. 0x8 SEED W: latch seed_pending, seed value; R returns 0. 0xC CTRL [0] run, R/W. Partial wstrb: byte lanes honoured for SEED; CTRL/STATUS use lane 0 only.
- FSM: S_IDLE -> S_SEED if seed_pending; else -> S_REQ if run && level+0 < DEPTH. S_REQ: rng_dat_re=1 one cycle -> S_WAIT. S_WAIT: first cycle with rng_dat_wait=0 capture rng_dat_do, push unless seed_pending (discard) -> S_IDLE. S_SEED: rng_dat_we=1, rng_dat_di=seed, flush FIFO, clear seed_pending -> S_IDLE.
- Seed priority over sampling; seed during S_WAIT waits for capture, captured word discarded.
- run=0: no new S_REQ; in-flight sample completes and is pushed.
- Simultaneous push and pop: level unchanged, popped word is the old head. Pop from empty in push cycle returns EMPTY_WORD (no bypass). Full: no request issued; never overflow. Pointers wrap mod DEPTH; level is DEPTH_LOG2+1 bits.
- Latency: empty to first word = 2 + RNG wait cycles.

Optional Feature:
RNG_HEALTH_EN: repetition test. Captured word equal to previous captured word is discarded and sets STATUS[20]; 4 consecutive repeats clear run. Without macro: no comparator, every captured word pushed, STATUS[20] reads 0.

Decomposition:
- Package rng_ctrl_pkg: register offsets, STATUS bit positions, FSM state enum (S_IDLE, S_REQ, S_WAIT, S_SEED), EMPTY_WORD default.
- Sub-module rng_sync_fifo: push/pop/flush, data_out, level, empty, full; parameter DEPTH_LOG2.

Test Plan:
- Reset, RNG model returns 0x1000_0000+n after 3 wait cycles -> STATUS level reaches 8, full=1, rng_dat_re pulses exactly 8 times.
- Read DATA 3x -> 0x1000_0000, 0x1000_0001, 0x1000_0002; each ready one cycle after valid; refill restores level 8.
- CTRL=0, drain 8, read DATA -> 0xFFFF_FFFF, STATUS[18]=1; write 0x0004_0000 to STATUS -> bit 18 clears.
- Write SEED 0xDEAD_BEEF during S_WAIT -> in-flight word discarded, rng_dat_we one cycle with di=0xDEAD_BEEF, level 0 then refills.
- Pop concurrent with push at level 5 -> level stays 5, FIFO order preserved.
- RNG_HEALTH_EN, model returns 0x1234_5678 repeatedly -> STATUS[20]=1, only one word stored, run=0 after 4 repeats.
